mac_seq: RTL and testbench
==========================

MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter BW, default 8, operand width; PE accumulator/result width is 2*BW.
REQ-002 Parameter LEN_W, default 8, width of operand-count and read-address fields.
REQ-003 i_clock  input  1  single clock; all state changes on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_start  input  1  request one dot-product job; sampled only in IDLE or DONE.
REQ-006 i_len  input  LEN_W  operand-pair count K for the job; latched when start is accepted.
REQ-007 o_busy  output  1  high in every state except IDLE.
REQ-008 o_rd_en  output  1  operand-memory read strobe; read data returns the next cycle.
REQ-009 o_rd_addr  output  LEN_W  operand-pair address, 0..K-1.
REQ-010 i_rd_act  input  BW  activation read data, one cycle after o_rd_en.
REQ-011 i_rd_wgt  input  BW  weight read data, one cycle after o_rd_en.
REQ-012 o_pe_activation  output  BW  to PE activation input.
REQ-013 o_pe_weight  output  BW  to PE weight input.
REQ-014 o_pe_clear  output  1  registered one-cycle pulse; the top level ORs it with i_reset onto the PE reset.
REQ-015 i_pe_output  input  2*BW  PE result.
REQ-016 o_result  output  2*BW  captured dot product.
REQ-017 o_result_valid  output  1  result handshake valid.
REQ-018 i_result_ready  input  1  result handshake ready.

Function
REQ-019 The FSM SHALL use states IDLE, CLEAR, FEED, DRAIN and DONE.
- IDLE->CLEAR: on i_start.
- CLEAR->FEED: after 1 cycle; goes to DRAIN instead if K=0.
- FEED->DRAIN: after K cycles.
- DRAIN->DONE: after 4 cycles.
- DONE->IDLE: on i_result_ready; goes to CLEAR instead if i_start is also high.
REQ-020 o_pe_clear SHALL be high exactly during the CLEAR cycle.
REQ-021 In FEED, o_rd_en SHALL be high each cycle, with o_rd_addr counting 0..K-1 one step per cycle.
REQ-022 The sequencer SHALL register o_rd_en as rd_valid. When rd_valid=1, o_pe_activation/o_pe_weight SHALL equal i_rd_act/i_rd_wgt combinationally; otherwise they SHALL be 0.
REQ-023 Operands SHALL be 0 in every cycle without rd_valid, so idle cycles add nothing to the PE accumulator and leave the PE operand registers zero before any clear.
REQ-024 DRAIN length SHALL be 4 cycles. This covers the PE pipeline (operand register, accumulate, result register) plus the last read cycle.
REQ-025 On the last DRAIN edge, o_result SHALL load i_pe_output.
REQ-026 o_result_valid SHALL be high exactly in DONE. o_result SHALL stay stable until the handshake completes.
REQ-027 Timing with start accepted at edge 0:
- CLEAR is cycle 1.
- FEED is cycles 2..K+1.
- DRAIN is cycles K+2..K+5.
- o_result_valid first rises in cycle K+6.
REQ-028 K=0 SHALL produce result 0 with o_result_valid in cycle 6.
REQ-029 Arithmetic SHALL wrap modulo 2^(2*BW), with no saturation or overflow flag.
REQ-030 i_start SHALL be ignored in CLEAR, FEED and DRAIN. i_len SHALL be ignored except on acceptance.
REQ-031 K SHALL range 0..2^LEN_W-1, and the address counter SHALL NOT wrap within a job.

Reset
REQ-032 On i_reset the FSM SHALL go to IDLE immediately, including mid-job; the job is discarded, not resumed.
REQ-033 Reset values:
- o_busy, o_rd_en, o_pe_clear, o_result_valid, rd_valid: 0.
- o_rd_addr, o_result: 0.
- latched K, counters: 0.
REQ-034 The first job after reset SHALL still issue its CLEAR cycle.

Structure
REQ-035 Package mac_seq_pkg SHALL hold the state enum and the constant PE_DRAIN_CYCLES=4.
REQ-036 The block SHALL be one module with no sub-module. The bench SHALL instantiate the real PE, with the reset OR as in REQ-014.

Verification
REQ-037 K=4, act {1,2,3,4}, wgt {5,6,7,8}, ready=1 -> o_result=70, valid in cycle 10 only.
REQ-038 K=0 -> o_pe_clear in cycle 1, no o_rd_en, o_result=0 valid in cycle 6.
REQ-039 BW=8, K=2, act=wgt=255 twice -> o_result=64514 (130050 mod 65536).
REQ-040 K=3, ready held low 5 cycles in DONE, i_start pulsed during FEED -> result held, valid held, start ignored.
REQ-041 DONE with start=1, ready=1, next K=2 (act{2,3}, wgt{4,5}) -> CLEAR next cycle, second result 23 with no leftover from the first job.
REQ-042 Reset asserted at FEED cycle 3 of a K=8 job, then a K=1 job (3x3) -> outputs zero during reset, result 9.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the dot-product sequencer.
package mac_seq_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  localparam int PE_DRAIN_CYCLES = 4;
endpackage

// File: rtl/mac_seq_pe.sv
// Processing element: operand register, accumulate, result register.
module mac_seq_pe #(
  parameter int BW = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [BW-1:0]   i_activation,
  input  logic [BW-1:0]   i_weight,
  output logic [2*BW-1:0] o_output
);
  logic [BW-1:0]   act_q, wgt_q;
  logic [2*BW-1:0] acc_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      act_q    <= '0;
      wgt_q    <= '0;
      acc_q    <= '0;
      o_output <= '0;
    end else begin
      act_q    <= i_activation;
      wgt_q    <= i_weight;
      acc_q    <= acc_q + (2*BW)'(act_q) * (2*BW)'(wgt_q);
      o_output <= acc_q;
    end
  end
endmodule

// File: rtl/mac_seq.sv
// Dot-product job sequencer: streams K operand pairs into a PE and captures the sum.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int BW    = 8,
  parameter int LEN_W = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic            o_busy,
  output logic            o_rd_en,
  output logic [LEN_W-1:0] o_rd_addr,
  input  logic [BW-1:0]   i_rd_act,
  input  logic [BW-1:0]   i_rd_wgt,
  output logic [BW-1:0]   o_pe_activation,
  output logic [BW-1:0]   o_pe_weight,
  output logic            o_pe_clear,
  input  logic [2*BW-1:0] i_pe_output,
  output logic [2*BW-1:0] o_result,
  output logic            o_result_valid,
  input  logic            i_result_ready
);
  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(PE_DRAIN_CYCLES - 1);

  state_t           state, state_n;
  logic [LEN_W-1:0] len_q, cnt;
  logic             rd_valid, clear_q;
  logic [LEN_W-1:0] feed_last;

  assign feed_last = len_q - 1'b1;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_start) state_n = CLEAR;
      CLEAR:   state_n = (len_q == '0) ? DRAIN : FEED;
      FEED:    if (cnt == feed_last) state_n = DRAIN;
      DRAIN:   if (cnt == DRAIN_LAST) state_n = DONE;
      DONE:    if (i_result_ready) state_n = i_start ? CLEAR : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One counter serves both FEED (read address) and DRAIN (latency wait);
  // it restarts at zero on every state change.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      len_q    <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      clear_q  <= 1'b0;
      o_result <= '0;
    end else begin
      clear_q  <= (state_n == CLEAR);
      rd_valid <= (state == FEED);
      if (state_n == CLEAR) len_q <= i_len;
      if (state != state_n) cnt <= '0;
      else if (state == FEED || state == DRAIN) cnt <= cnt + 1'b1;
      if (state == DRAIN && state_n == DONE) o_result <= i_pe_output;
    end
  end

  assign o_busy         = (state != IDLE);
  assign o_rd_en        = (state == FEED);
  assign o_rd_addr      = o_rd_en ? cnt : '0;
  assign o_pe_clear     = clear_q;
  assign o_result_valid = (state == DONE);
  // Zero operands outside returning reads so idle cycles contribute nothing.
  assign o_pe_activation = rd_valid ? i_rd_act : '0;
  assign o_pe_weight     = rd_valid ? i_rd_wgt : '0;
endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq driving a real PE and a one-cycle-latency operand memory.
module tb_mac_seq;
  localparam int BW = 8;
  localparam int LEN_W = 8;

  logic             i_clock = 1'b0;
  logic             i_reset, i_start, i_result_ready;
  logic [LEN_W-1:0] i_len;
  logic             o_busy, o_rd_en, o_pe_clear, o_result_valid;
  logic [LEN_W-1:0] o_rd_addr;
  logic [BW-1:0]    i_rd_act = '0, i_rd_wgt = '0, o_pe_activation, o_pe_weight;
  logic [2*BW-1:0]  pe_out, o_result;
  logic             pe_rst;
  logic [BW-1:0]    act_mem [0:255];
  logic [BW-1:0]    wgt_mem [0:255];
  int checks = 0, errors = 0;

  always #5 i_clock = ~i_clock;

  mac_seq #(.BW(BW), .LEN_W(LEN_W)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_len(i_len),
    .o_busy(o_busy), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_act(i_rd_act), .i_rd_wgt(i_rd_wgt),
    .o_pe_activation(o_pe_activation), .o_pe_weight(o_pe_weight),
    .o_pe_clear(o_pe_clear), .i_pe_output(pe_out),
    .o_result(o_result), .o_result_valid(o_result_valid),
    .i_result_ready(i_result_ready)
  );

  assign pe_rst = i_reset | o_pe_clear;

  mac_seq_pe #(.BW(BW)) pe (
    .i_clock(i_clock), .i_reset(pe_rst),
    .i_activation(o_pe_activation), .i_weight(o_pe_weight), .o_output(pe_out)
  );

  // Junk data when not reading, so unmasked operands would corrupt the sum.
  always @(posedge i_clock) begin
    i_rd_act <= o_rd_en ? act_mem[o_rd_addr] : 8'hEE;
    i_rd_wgt <= o_rd_en ? wgt_mem[o_rd_addr] : 8'hEE;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},  32'(o_busy), 0);
    chk({tag, ".rd_en"}, 32'(o_rd_en), 0);
    chk({tag, ".addr"},  32'(o_rd_addr), 0);
    chk({tag, ".clear"}, 32'(o_pe_clear), 0);
    chk({tag, ".valid"}, 32'(o_result_valid), 0);
    chk({tag, ".result"}, 32'(o_result), 0);
    chk({tag, ".pe_act"}, 32'(o_pe_activation), 0);
  endtask

  // Called just before an accepting edge; returns #1 after it (edge 0).
  task automatic launch(input int k);
    i_start = 1'b1;
    i_len   = LEN_W'(k);
    @(posedge i_clock);
    #1;
    i_start = 1'b0;
    i_len   = 8'hFF;
  endtask

  // Samples cycles 1..K+6 at negedges; returns at the first DONE cycle.
  task automatic watch(input string tag, input int k, input logic [15:0] exp, input bit pulse);
    int clr_n = 0, clr_at = 0, rd_n = 0, rd_bad = 0, addr_bad = 0, vld_early = 0, idle_n = 0;
    for (int c = 1; c <= k + 6; c++) begin
      @(negedge i_clock);
      if (pulse && c == 3) i_start = 1'b1;
      if (pulse && c == 4) i_start = 1'b0;
      if (o_pe_clear) begin clr_n++; clr_at = c; end
      if (o_rd_en) begin
        if (o_rd_addr != rd_n[LEN_W-1:0]) addr_bad++;
        if (c < 2 || c > k + 1) rd_bad++;
        rd_n++;
      end
      if (o_result_valid && c < k + 6) vld_early++;
      if (!o_busy) idle_n++;
    end
    chk({tag, ".clear_n"},  clr_n, 1);
    chk({tag, ".clear_at"}, clr_at, 1);
    chk({tag, ".rd_n"},     rd_n, k);
    chk({tag, ".rd_win"},   rd_bad, 0);
    chk({tag, ".addr"},     addr_bad, 0);
    chk({tag, ".vld_early"}, vld_early, 0);
    chk({tag, ".busy"},     idle_n, 0);
    chk({tag, ".valid"},    32'(o_result_valid), 1);
    chk({tag, ".result"},   32'(o_result), 32'(exp));
  endtask

  task automatic expect_idle(input string tag);
    @(negedge i_clock);
    chk({tag, ".valid_off"}, 32'(o_result_valid), 0);
    chk({tag, ".idle"},      32'(o_busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin act_mem[i] = 8'h00; wgt_mem[i] = 8'h00; end
    i_reset = 1'b1; i_start = 1'b0; i_len = '0; i_result_ready = 1'b1;
    repeat (2) @(negedge i_clock);
    chk_zero("reset");
    i_reset = 1'b0;

    // K=4: 1*5 + 2*6 + 3*7 + 4*8 = 70, valid in cycle 10 only
    act_mem[0] = 1; act_mem[1] = 2; act_mem[2] = 3; act_mem[3] = 4;
    wgt_mem[0] = 5; wgt_mem[1] = 6; wgt_mem[2] = 7; wgt_mem[3] = 8;
    @(negedge i_clock);
    launch(4);
    watch("k4", 4, 16'd70, 1'b0);
    expect_idle("k4");

    // K=0: clear only, result 0 in cycle 6
    launch(0);
    watch("k0", 0, 16'd0, 1'b0);
    expect_idle("k0");

    // K=2 with 255*255 twice wraps to 64514, then chained start from DONE
    act_mem[0] = 255; act_mem[1] = 255; wgt_mem[0] = 255; wgt_mem[1] = 255;
    @(negedge i_clock);
    launch(2);
    watch("wrap", 2, 16'd64514, 1'b0);
    act_mem[0] = 2; act_mem[1] = 3; wgt_mem[0] = 4; wgt_mem[1] = 5;
    launch(2);
    watch("chain", 2, 16'd23, 1'b0);
    expect_idle("chain");

    // K=3, ready held low in DONE, start pulsed mid-FEED: 10+40+90 = 140
    act_mem[0] = 10; act_mem[1] = 20; act_mem[2] = 30;
    wgt_mem[0] = 1;  wgt_mem[1] = 2;  wgt_mem[2] = 3;
    i_result_ready = 1'b0;
    @(negedge i_clock);
    launch(3);
    watch("hold", 3, 16'd140, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clock);
      chk("hold.valid",  32'(o_result_valid), 1);
      chk("hold.result", 32'(o_result), 140);
      chk("hold.clear",  32'(o_pe_clear), 0);
    end
    i_result_ready = 1'b1;
    expect_idle("hold");

    // Reset mid-FEED of a K=8 job, then K=1 job 3*3 = 9
    for (int i = 0; i < 8; i++) begin act_mem[i] = 8'(i + 7); wgt_mem[i] = 8'(i + 11); end
    @(negedge i_clock);
    launch(8);
    repeat (4) @(negedge i_clock);
    i_reset = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge i_clock);
    chk_zero("midrst2");
    i_reset = 1'b0;
    act_mem[0] = 3; wgt_mem[0] = 3;
    @(negedge i_clock);
    launch(1);
    watch("postrst", 1, 16'd9, 1'b0);
    expect_idle("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
